// File: rtl/cart_mem_pkg.sv
// cart_mem_pkg: shared types and constants for the cartridge memory bus
// logic (arbiter, cycle timer, serial/EEPROM sequencers).
package cart_mem_pkg;

  localparam int ADDR_W      = 23;  // requester byte address
  localparam int CHIP_ADDR_W = 22;  // address pins on each chip
  localparam int DATA_W      = 8;
  localparam int RAM_SEL_BIT = 22;  // addr[22]=1 -> RAM, 0 -> ROM
  localparam int TIMER_W     = 4;
  localparam int STARVE_W    = 8;

  localparam int DEF_ACCESS_CYCLES = 3;
  localparam int DEF_AUX_STARVE    = 8;

  // Read-data registers come out of reset looking like an undriven bus.
  localparam logic [DATA_W-1:0] RDATA_RST = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } cart_mem_state_e;

endpackage

// File: rtl/mem_cycle_timer.sv
// mem_cycle_timer: loadable down-counter with a zero flag.
//   CLK, RSTn  clock, async active-low reset (count resets to 0)
//   load       load load_val this cycle (wins over dec)
//   load_val   value to load
//   dec        decrement by one; ignored once the count is 0
//   zero       count == 0
module mem_cycle_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (dec && !zero)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: shares the cartridge ROM/RAM chip bus between the host
// mapper path and the aux loader/debug port. Each grant runs one byte cycle:
// SETUP (1) -> STROBE (ACCESS_CYCLES) -> HOLD (1) -> DONE (1, ack).
//   h_*/a_*     level requests held until ack; ack is a one-cycle pulse,
//               rdata is valid in the ack cycle and held until the next read
//   aux_en      0 blocks aux grants and holds the starvation count at 0
//   mem_*       chip address/data, rom/ram CE, OE and WE (all active-low
//               strobes); every chip-side output is registered
module cart_mem_arbiter
  import cart_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,  // 1..15
  parameter int AUX_STARVE    = DEF_AUX_STARVE      // 1..255
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   aux_en,
  input  logic                   h_req,
  input  logic                   h_we,
  input  logic [ADDR_W-1:0]      h_addr,
  input  logic [DATA_W-1:0]      h_wdata,
  output logic                   h_ack,
  output logic [DATA_W-1:0]      h_rdata,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_wdata,
  output logic                   a_ack,
  output logic [DATA_W-1:0]      a_rdata,
  output logic [CHIP_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_dq_o,
  output logic                   mem_dq_oe,
  input  logic [DATA_W-1:0]      mem_dq_i,
  output logic                   rom_ce_n,
  output logic                   ram_ce_n,
  output logic                   mem_oe_n,
  output logic                   mem_we_n
);

  cart_mem_state_e         state_q, state_d;
  logic [STARVE_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic                    owner_aux_q, owner_aux_d;
  logic                    we_q, we_d;
  logic [CHIP_ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_dq_o_q, mem_dq_o_d;
  logic                    mem_dq_oe_q, mem_dq_oe_d;
  logic                    rom_ce_n_q, rom_ce_n_d;
  logic                    ram_ce_n_q, ram_ce_n_d;
  logic                    mem_oe_n_q, mem_oe_n_d;
  logic                    mem_we_n_q, mem_we_n_d;
  logic                    h_ack_q, h_ack_d;
  logic                    a_ack_q, a_ack_d;
  logic [DATA_W-1:0]       h_rdata_q, h_rdata_d;
  logic [DATA_W-1:0]       a_rdata_q, a_rdata_d;

  logic                    tmr_load, tmr_dec, tmr_zero;

  // Arbitration: host first, aux when it is the only requester or starved.
  logic              aux_elig, aux_wins, grant_aux, grant_any;
  logic [ADDR_W-1:0] g_addr;
  logic              g_we;
  logic [DATA_W-1:0] g_wdata;

  assign aux_elig  = a_req && aux_en;
  assign aux_wins  = aux_elig && (starve_cnt_q >= STARVE_W'(AUX_STARVE));
  assign grant_aux = aux_wins || (aux_elig && !h_req);
  assign grant_any = h_req || aux_elig;
  assign g_addr    = grant_aux ? a_addr  : h_addr;
  assign g_we      = grant_aux ? a_we    : h_we;
  assign g_wdata   = grant_aux ? a_wdata : h_wdata;

  mem_cycle_timer #(.W(TIMER_W)) u_timer (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .load     (tmr_load),
    .load_val (TIMER_W'(ACCESS_CYCLES - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Outputs are computed for the state being entered so they are registered
  // and line up exactly with that state's cycles.
  always_comb begin
    state_d     = state_q;
    owner_aux_d = owner_aux_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_dq_o_d  = mem_dq_o_q;
    mem_dq_oe_d = mem_dq_oe_q;
    rom_ce_n_d  = rom_ce_n_q;
    ram_ce_n_d  = ram_ce_n_q;
    mem_oe_n_d  = mem_oe_n_q;
    mem_we_n_d  = mem_we_n_q;
    h_rdata_d   = h_rdata_q;
    a_rdata_d   = a_rdata_q;
    h_ack_d     = 1'b0;
    a_ack_d     = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    // A waiting aux only accrues starvation while it is actually eligible.
    starve_cnt_d = aux_elig ? starve_cnt_q : '0;

    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d     = SETUP;
          owner_aux_d = grant_aux;
          we_d        = g_we;
          mem_addr_d  = g_addr[CHIP_ADDR_W-1:0];
          mem_dq_o_d  = g_wdata;
          mem_dq_oe_d = g_we;
          ram_ce_n_d  = !g_addr[RAM_SEL_BIT];
          rom_ce_n_d  =  g_addr[RAM_SEL_BIT];
          if (grant_aux)
            starve_cnt_d = '0;
          else if (aux_elig && starve_cnt_q != '1)
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
      SETUP: begin
        state_d    = STROBE;
        tmr_load   = 1'b1;
        mem_oe_n_d = we_q;
        mem_we_n_d = !we_q;
      end
      STROBE: begin
        if (tmr_zero) begin
          state_d    = HOLD;
          mem_oe_n_d = 1'b1;
          mem_we_n_d = 1'b1;
          // Sample read data at the edge that closes the strobe.
          if (!we_q) begin
            if (owner_aux_q) a_rdata_d = mem_dq_i;
            else             h_rdata_d = mem_dq_i;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      HOLD: begin
        state_d     = DONE;
        rom_ce_n_d  = 1'b1;
        ram_ce_n_d  = 1'b1;
        mem_dq_oe_d = 1'b0;
        h_ack_d     = !owner_aux_q;
        a_ack_d     = owner_aux_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      owner_aux_q  <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_dq_o_q   <= '0;
      mem_dq_oe_q  <= 1'b0;
      rom_ce_n_q   <= 1'b1;
      ram_ce_n_q   <= 1'b1;
      mem_oe_n_q   <= 1'b1;
      mem_we_n_q   <= 1'b1;
      h_ack_q      <= 1'b0;
      a_ack_q      <= 1'b0;
      h_rdata_q    <= RDATA_RST;
      a_rdata_q    <= RDATA_RST;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_aux_q  <= owner_aux_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_dq_o_q   <= mem_dq_o_d;
      mem_dq_oe_q  <= mem_dq_oe_d;
      rom_ce_n_q   <= rom_ce_n_d;
      ram_ce_n_q   <= ram_ce_n_d;
      mem_oe_n_q   <= mem_oe_n_d;
      mem_we_n_q   <= mem_we_n_d;
      h_ack_q      <= h_ack_d;
      a_ack_q      <= a_ack_d;
      h_rdata_q    <= h_rdata_d;
      a_rdata_q    <= a_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_dq_o  = mem_dq_o_q;
  assign mem_dq_oe = mem_dq_oe_q;
  assign rom_ce_n  = rom_ce_n_q;
  assign ram_ce_n  = ram_ce_n_q;
  assign mem_oe_n  = mem_oe_n_q;
  assign mem_we_n  = mem_we_n_q;
  assign h_ack     = h_ack_q;
  assign a_ack     = a_ack_q;
  assign h_rdata   = h_rdata_q;
  assign a_rdata   = a_rdata_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb_cart_mem_arbiter: scoreboard bench. Expected transfers are queued when
// requests are driven; a bus monitor measures each transfer's CE/OE/WE/DQ_OE
// pulse widths and pops/compares on every ack.
module tb_cart_mem_arbiter;

  localparam int AC     = 3;
  localparam int STARVE = 8;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        aux_en;
  logic        h_req, h_we, h_ack, a_req, a_we, a_ack;
  logic [22:0] h_addr, a_addr;
  logic [7:0]  h_wdata, a_wdata, h_rdata, a_rdata;
  logic [21:0] mem_addr;
  logic [7:0]  mem_dq_o, mem_dq_i;
  logic        mem_dq_oe, rom_ce_n, ram_ce_n, mem_oe_n, mem_we_n;

  cart_mem_arbiter #(.ACCESS_CYCLES(AC), .AUX_STARVE(STARVE)) dut (
    .CLK(CLK), .RSTn(RSTn), .aux_en(aux_en),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
    .mem_dq_i(mem_dq_i), .rom_ce_n(rom_ce_n), .ram_ce_n(ram_ce_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  always #5 CLK = ~CLK;

  // Chip model: read data is a fixed function of the address.
  assign mem_dq_i = mem_addr[7:0] ^ 8'h79;

  typedef struct {
    bit          aux;
    bit          we;
    logic [22:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  txn_t       sb[$];
  txn_t       e;
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] last_rd [2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Bus monitor / scoreboard consumer
  int          ce_cnt, oe_cnt, we_cnt, dqoe_cnt;
  logic [22:0] seen_addr;
  logic [7:0]  seen_dq, exp_rd;

  initial begin
    ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
    seen_addr = '0; seen_dq = '0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
      end else begin
        if (!rom_ce_n || !ram_ce_n) begin
          ce_cnt++;
          seen_addr = {!ram_ce_n, mem_addr};
          chk("ce_excl", 32'(!rom_ce_n && !ram_ce_n), 0);
          chk("strb_excl", 32'(!mem_oe_n && !mem_we_n), 0);
        end else begin
          chk("idle_strobes", {mem_oe_n, mem_we_n, mem_dq_oe}, 3'b110);
        end
        if (!mem_oe_n) oe_cnt++;
        if (!mem_we_n) begin we_cnt++; seen_dq = mem_dq_o; end
        if (mem_dq_oe) dqoe_cnt++;
        if (h_ack || a_ack) begin
          if (sb.size() == 0) begin
            chk("unexp_ack", {h_ack, a_ack}, 0);
          end else begin
            e = sb.pop_front();
            chk("ack_owner", {h_ack, a_ack}, e.aux ? 2'b01 : 2'b10);
            chk("addr", seen_addr, e.addr);
            chk("ce_len", ce_cnt, AC + 2);
            chk("oe_len", oe_cnt, e.we ? 0 : AC);
            chk("we_len", we_cnt, e.we ? AC : 0);
            chk("dqoe_len", dqoe_cnt, e.we ? AC + 2 : 0);
            if (e.we) chk("wdata", seen_dq, e.wdata);
            exp_rd = e.we ? last_rd[e.aux] : (e.addr[7:0] ^ 8'h79);
            last_rd[e.aux] = exp_rd;
            chk("rdata", e.aux ? a_rdata : h_rdata, exp_rd);
          end
          ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
        end
      end
    end
  end

  task automatic wait_ack(output bit got, output int c);
    got = 1'b0;
    c   = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (h_ack || a_ack) begin got = 1'b1; c = cyc; end
    end
    if (!got) chk("ack_timeout", 0, 1);
  endtask

  // Called just after a posedge with the arbiter idle.
  task automatic do_xfer(input bit aux, input bit we, input logic [22:0] addr,
                         input logic [7:0] wd, input bit chk_lat);
    int t0, c;
    bit got;
    if (aux) begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    else     begin h_we = we; h_addr = addr; h_wdata = wd; h_req = 1'b1; end
    sb.push_back('{aux, we, addr, wd});
    t0 = cyc;
    wait_ack(got, c);
    if (got && chk_lat) chk("latency", c - t0, AC + 3);
    @(posedge CLK); #1;
    if (aux) a_req = 1'b0; else h_req = 1'b0;
  endtask

  initial begin
    int  c1, c2, hc, ac, m, saw;
    bit  got, seen;
    aux_en = 1'b1;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    last_rd[0] = 8'hFF; last_rd[1] = 8'hFF;

    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
    chk("rst_strobes", {rom_ce_n, ram_ce_n, mem_oe_n, mem_we_n, mem_dq_oe}, 5'b11110);
    chk("rst_rdata", {h_rdata, a_rdata}, 16'hFFFF);
    chk("rst_addr_dq", {mem_addr, mem_dq_o}, 0);
    chk("rst_ack", {h_ack, a_ack}, 0);
    @(posedge CLK); #1;

    // Single transfers, including address extremes
    do_xfer(0, 0, 23'h400123, 8'h00, 1);
    chk("h_rdata_5a", h_rdata, 8'h5A);
    do_xfer(1, 1, 23'h012345, 8'hC3, 1);
    chk("idle_addr_hold", mem_addr, 22'h012345);
    chk("idle_dq_hold", mem_dq_o, 8'hC3);
    do_xfer(1, 0, 23'h7FFFFF, 8'h00, 1);
    do_xfer(0, 1, 23'h000000, 8'h5E, 1);
    do_xfer(0, 0, 23'h3FFFFF, 8'h00, 1);

    // Host holds req through ack: next transfer after one idle cycle
    h_we = 0; h_addr = 23'h000010; h_req = 1'b1;
    sb.push_back('{0, 0, 23'h000010, 8'h00});
    wait_ack(got, c1);
    @(posedge CLK); #1;
    h_we = 1; h_addr = 23'h400020; h_wdata = 8'h99;
    sb.push_back('{0, 1, 23'h400020, 8'h99});
    wait_ack(got, c2);
    chk("b2b_gap", c2 - c1, AC + 4);
    @(posedge CLK); #1 h_req = 1'b0;

    // aux_en=0: aux held but ignored, starvation count stays clear
    aux_en = 1'b0;
    a_we = 0; a_addr = 23'h000055; a_req = 1'b1;
    do_xfer(0, 0, 23'h000031, 8'h00, 1);
    do_xfer(0, 1, 23'h400032, 8'h11, 1);
    do_xfer(0, 0, 23'h000033, 8'h00, 1);
    chk("starve_held", dut.starve_cnt_q, 0);
    a_req = 1'b0;
    aux_en = 1'b1;
    @(posedge CLK); #1;

    // Continuous contention: predicted grant order from a starvation model
    m = 0;
    for (int i = 0; i < 18; i++) begin
      if (m >= STARVE) begin sb.push_back('{1, 0, 23'h400200, 8'h00}); m = 0; end
      else             begin sb.push_back('{0, 0, 23'h000100, 8'h00}); m++; end
    end
    h_we = 0; h_addr = 23'h000100; a_we = 0; a_addr = 23'h400200;
    h_req = 1'b1; a_req = 1'b1;
    hc = 0; ac = 0;
    for (int i = 0; i < 400 && (hc < 16 || ac < 2); i++) begin
      @(negedge CLK);
      if (h_ack) hc++;
      if (a_ack) ac++;
      if (h_ack || a_ack) begin
        @(posedge CLK); #1;
        if (hc >= 16) h_req = 1'b0;
        if (ac >= 2)  a_req = 1'b0;
      end
    end
    h_req = 1'b0; a_req = 1'b0;
    chk("cont_host_acks", hc, 16);
    chk("cont_aux_acks", ac, 2);
    chk("sb_drained", sb.size(), 0);
    repeat (2) @(posedge CLK); #1;

    // Reset in the middle of the strobe
    h_we = 0; h_addr = 23'h400055; h_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (!mem_oe_n) seen = 1'b1;
    end
    if (!seen) chk("strobe_timeout", 0, 1);
    #2 RSTn = 1'b0;
    #1;
    chk("rst_mid_strobes", {rom_ce_n, ram_ce_n, mem_oe_n, mem_we_n, mem_dq_oe}, 5'b11110);
    chk("rst_mid_ack", {h_ack, a_ack}, 0);
    h_req = 1'b0;
    sb.delete();
    last_rd[0] = 8'hFF; last_rd[1] = 8'hFF;
    @(negedge CLK); #2 RSTn = 1'b1;
    saw = 0;
    repeat (12) begin
      @(negedge CLK);
      if (h_ack || a_ack) saw++;
    end
    chk("no_ack_after_rst", saw, 0);
    chk("rdata_after_rst", {h_rdata, a_rdata}, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
